// File: rtl/common_pkg.sv
// Shared types for the oscillator-loop blocks: phase and neighbour-term
// formats, the updater state encoding and the noise LFSR seed.
package common_pkg;

    localparam int PHASE_W = 6;
    localparam int NL_W    = 8;

    typedef logic        [PHASE_W-1:0] phase_t;
    typedef logic signed [NL_W-1:0]    NL_out_phase_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_UPDATE = 2'd2
    } updater_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/phase_updater_sat_accum.sv
// sat_accum: signed accumulator with saturation at the ACC_W range limits,
// synchronous clear, and a flag marking the add that clipped.
module sat_accum #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    add_en,
    input  logic signed [IN_W-1:0]  din,
    output logic signed [ACC_W-1:0] acc,
    output logic                    sat
);

    // One guard bit is enough: a single IN_W term cannot overflow ACC_W+1 bits.
    function automatic logic signed [ACC_W:0] wide_sum(
        input logic signed [ACC_W-1:0] a,
        input logic signed [IN_W-1:0]  b
    );
        logic signed [ACC_W:0] a_ext;
        logic signed [ACC_W:0] b_ext;
        a_ext = {a[ACC_W-1], a};
        b_ext = {{(ACC_W+1-IN_W){b[IN_W-1]}}, b};
        return a_ext + b_ext;
    endfunction

    function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W:0] s);
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    logic signed [ACC_W:0] sum_w;

    assign sum_w = wide_sum(acc, din);
    assign sat   = add_en & (sum_w[ACC_W] ^ sum_w[ACC_W-1]);

    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (add_en)
            acc <= saturate(sum_w);
    end

endmodule

// File: rtl/phase_updater.sv
// phase_updater: accumulates a framed gradient/Hamiltonian stream and applies a
// shifted gradient-descent step to the self phase. `PHASE_NOISE_EN adds LFSR dither.
module phase_updater
    import common_pkg::*;
#(
    parameter int STEP_SHIFT = 2,
    parameter int MAX_NEIGH  = 16,
    parameter int ITER_W     = 16
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        ena,
    input  logic                                        init_valid,
    input  phase_t                                      init_phase,
    input  logic                                        grad_valid,
    output logic                                        grad_ready,
    input  NL_out_phase_t                               grad_in,
    input  NL_out_phase_t                               ham_in,
    input  logic                                        grad_last,
    output phase_t                                      self_phase,
    output logic                                        phase_update,
    output logic signed [NL_W+$clog2(MAX_NEIGH)-1:0]    energy,
    output logic                                        energy_valid,
    output logic                                        sat_flag,
    output logic [ITER_W-1:0]                           iter_count
);

    localparam int ACC_W = NL_W + $clog2(MAX_NEIGH);

    updater_state_t state_q, state_d;
    logic accept;
    logic upd_en;
    logic acc_clr;
    logic init_en;

    logic signed [ACC_W-1:0] g_acc, h_acc;
    logic g_sat, h_sat;

    phase_t delta_lo;
    phase_t noise_ext;

    logic                    vld_p1;
    phase_t                  delta_p1;
    logic signed [ACC_W-1:0] energy_p1;

    assign init_en = ena & init_valid;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        grad_ready = ena & ~init_valid & (state_q != ST_UPDATE);
        accept     = grad_valid & grad_ready;
        upd_en     = ena & ~init_valid & (state_q == ST_UPDATE);
        acc_clr    = init_en | upd_en;
        if (init_en) begin
            state_d = ST_IDLE;
        end else if (ena) begin
            unique case (state_q)
                ST_IDLE:   if (accept) state_d = grad_last ? ST_UPDATE : ST_ACCUM;
                ST_ACCUM:  if (accept && grad_last) state_d = ST_UPDATE;
                ST_UPDATE: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    sat_accum #(.IN_W(NL_W), .ACC_W(ACC_W)) u_g_acc (
        .clk    (clk),
        .reset  (reset),
        .clr    (acc_clr),
        .add_en (accept),
        .din    (grad_in),
        .acc    (g_acc),
        .sat    (g_sat)
    );

    sat_accum #(.IN_W(NL_W), .ACC_W(ACC_W)) u_h_acc (
        .clk    (clk),
        .reset  (reset),
        .clr    (acc_clr),
        .add_en (accept),
        .din    (ham_in),
        .acc    (h_acc),
        .sat    (h_sat)
    );

`ifdef PHASE_NOISE_EN
    logic [15:0]       lfsr;
    logic signed [1:0] noise;

    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= LFSR_SEED;
        else if (upd_en)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign noise     = $signed(lfsr[1:0]);
    assign noise_ext = phase_t'(noise);
`else
    assign noise_ext = '0;
`endif

    // Only the low PHASE_W bits matter: the phase wraps, so the step is taken mod 2^PHASE_W.
    assign delta_lo = phase_t'(g_acc >>> STEP_SHIFT) + noise_ext;

    // ---- stage p1: capture step and energy during UPDATE ----
    always_ff @(posedge clk) begin
        if (reset)
            vld_p1 <= 1'b0;
        else if (ena)
            vld_p1 <= upd_en;
    end

    always_ff @(posedge clk) begin
        if (upd_en) begin
            delta_p1  <= delta_lo;
            energy_p1 <= h_acc;
        end
    end

    // ---- stage p2: commit phase, energy, counter and pulses ----
    always_ff @(posedge clk) begin
        if (reset) begin
            self_phase   <= '0;
            energy       <= '0;
            iter_count   <= '0;
            sat_flag     <= 1'b0;
            phase_update <= 1'b0;
            energy_valid <= 1'b0;
        end else if (ena) begin
            if (init_valid) begin
                self_phase   <= init_phase;
                sat_flag     <= 1'b0;
                phase_update <= 1'b0;
                energy_valid <= 1'b0;
            end else begin
                phase_update <= vld_p1;
                energy_valid <= vld_p1;
                if (vld_p1) begin
                    self_phase <= self_phase - delta_p1;
                    energy     <= energy_p1;
                    iter_count <= iter_count + ITER_W'(1);
                end
                if (accept && (g_sat || h_sat))
                    sat_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phase_updater.sv
// Scoreboard bench for phase_updater: a frame-level model predicts each update,
// a monitor checks every phase_update pulse against the queued expectation.
module tb_phase_updater;
    import common_pkg::*;

    localparam int ACC_W   = 12;
    localparam int ACC_MAX = 2047;
    localparam int ACC_MIN = -2048;
    localparam int STEP    = 4;

    logic clk = 1'b0;
    logic reset, ena, init_valid, grad_valid, grad_ready, grad_last;
    logic phase_update, energy_valid, sat_flag;
    phase_t init_phase, self_phase;
    NL_out_phase_t grad_in, ham_in;
    logic signed [ACC_W-1:0] energy;
    logic [15:0] iter_count;

    phase_updater dut (
        .clk          (clk),
        .reset        (reset),
        .ena          (ena),
        .init_valid   (init_valid),
        .init_phase   (init_phase),
        .grad_valid   (grad_valid),
        .grad_ready   (grad_ready),
        .grad_in      (grad_in),
        .ham_in       (ham_in),
        .grad_last    (grad_last),
        .self_phase   (self_phase),
        .phase_update (phase_update),
        .energy       (energy),
        .energy_valid (energy_valid),
        .sat_flag     (sat_flag),
        .iter_count   (iter_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int phase;
        int energy;
        int iter;
        bit sat;
        int acc_cyc;
        int lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int m_phase, m_g, m_h, m_iter;
    bit m_sat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int floor_div(input int s);
        if (s >= 0) return s / STEP;
        return -((-s + STEP - 1) / STEP);
    endfunction

    function automatic int mod64(input int x);
        return ((x % 64) + 64) % 64;
    endfunction

    function automatic int clamp(input int x, inout bit hit);
        if (x > ACC_MAX) begin hit = 1'b1; return ACC_MAX; end
        if (x < ACC_MIN) begin hit = 1'b1; return ACC_MIN; end
        return x;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_g = 0; m_h = 0; m_iter = 0; m_sat = 1'b0;
    endtask

    task automatic model_beat(input int g, input int h, input bit last, input int stall);
        exp_t e;
        m_g = clamp(m_g + g, m_sat);
        m_h = clamp(m_h + h, m_sat);
        if (last) begin
            m_phase = mod64(m_phase - floor_div(m_g));
            m_iter  = (m_iter + 1) % 65536;
            e.phase = m_phase; e.energy = m_h; e.iter = m_iter; e.sat = m_sat;
            e.acc_cyc = cyc; e.lat = 2 + stall;
            sb.push_back(e);
            m_g = 0; m_h = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic freeze(input int n);
        phase_t      p0 = self_phase;
        logic [15:0] i0 = iter_count;
        int          e0 = energy;
        int          rdy = 0;
        ena = 1'b0;
        grad_valid = 1'b1; grad_in = 8'sd55; ham_in = 8'sd55; grad_last = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rdy += int'(grad_ready);
            @(posedge clk);
            #1;
        end
        chk("freeze_ready", rdy, 0);
        chk("freeze_phase", self_phase, p0);
        chk("freeze_iter", iter_count, i0);
        chk("freeze_energy", energy, e0);
        grad_valid = 1'b0;
        ena = 1'b1;
    endtask

    task automatic send_beat(input int g, input int h, input bit last, input int stall,
                             output int waited);
        bit took = 1'b0;
        waited = 0;
        grad_valid = 1'b1;
        grad_in = NL_out_phase_t'(g);
        ham_in = NL_out_phase_t'(h);
        grad_last = last;
        while (!took && waited <= 50) begin
            @(negedge clk);
            took = grad_ready;
            @(posedge clk);
            #1;
            if (!took) waited++;
        end
        grad_valid = 1'b0;
        grad_last = 1'b0;
        if (!took) chk("beat_timeout", 1, 0);
        else model_beat(g, h, last, stall);
        if (stall > 0) freeze(stall);
    endtask

    task automatic do_init(input int p);
        init_valid = 1'b1;
        init_phase = phase_t'(p);
        @(posedge clk);
        #1;
        init_valid = 1'b0;
        m_phase = p; m_g = 0; m_h = 0; m_sat = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        chk({tag, "_phase"}, self_phase, 0);
        chk({tag, "_energy"}, energy, 0);
        chk({tag, "_iter"}, iter_count, 0);
        chk({tag, "_sat"}, sat_flag, 0);
        chk({tag, "_pulse"}, phase_update, 0);
        chk({tag, "_evalid"}, energy_valid, 0);
        chk({tag, "_ready"}, grad_ready, 1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (phase_update) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_phase", self_phase, mon_e.phase);
                chk("pulse_energy", energy, mon_e.energy);
                chk("pulse_iter", iter_count, mon_e.iter);
                chk("pulse_sat", sat_flag, mon_e.sat);
                chk("pulse_evalid", energy_valid, 1);
                chk("pulse_latency", cyc - mon_e.acc_cyc, mon_e.lat);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset = 1'b1; ena = 1'b1; init_valid = 1'b0; init_phase = '0;
        grad_valid = 1'b0; grad_in = '0; ham_in = '0; grad_last = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state("reset");

        // Two-beat frame from phase 21.
        do_init(21);
        send_beat(8, 3, 1'b0, 0, w);
        send_beat(8, -5, 1'b1, 0, w);
        idle(4);
        chk("t1_phase", self_phase, 17);
        chk("t1_energy", energy, -2);
        chk("t1_iter", iter_count, 1);

        // Single-beat frames, negative step and wrap-around.
        do_init(2);
        send_beat(-13, 0, 1'b1, 0, w);
        idle(4);
        chk("neg_step_phase", self_phase, 6);
        do_init(1);
        send_beat(16, 0, 1'b1, 0, w);
        idle(4);
        chk("wrap_phase", self_phase, 61);

        // Saturating overrun of the gradient sum.
        do_init(10);
        for (int b = 0; b < 20; b++) send_beat(127, 0, b == 19, 0, w);
        idle(4);
        chk("sat_phase", self_phase, 11);
        chk("sat_flag_set", sat_flag, 1);
        send_beat(0, 0, 1'b1, 0, w);
        idle(4);
        chk("sat_flag_sticky", sat_flag, 1);
        do_init(5);
        @(negedge clk);
        chk("sat_flag_init_clear", sat_flag, 0);
        @(posedge clk);
        #1;

        // Init aborts a frame in progress.
        do_init(0);
        send_beat(5, 1, 1'b0, 0, w);
        send_beat(6, 1, 1'b0, 0, w);
        send_beat(7, 1, 1'b0, 0, w);
        do_init(40);
        @(negedge clk);
        chk("abort_phase", self_phase, 40);
        @(posedge clk);
        #1;
        send_beat(4, 0, 1'b1, 0, w);
        idle(4);
        chk("abort_next_phase", self_phase, 39);

        // ena held low mid-frame and across UPDATE.
        do_init(30);
        send_beat(20, 2, 1'b0, 0, w);
        freeze(5);
        send_beat(12, 1, 1'b1, 5, w);
        idle(4);
        chk("ena_phase", self_phase, 22);

        // Beat offered during UPDATE waits exactly one cycle.
        send_beat(4, 1, 1'b1, 0, w);
        send_beat(8, 0, 1'b1, 0, w);
        chk("update_wait", w, 1);
        idle(4);

        // Reset in ACCUM discards partial sums.
        send_beat(3, 3, 1'b0, 0, w);
        send_beat(3, 3, 1'b0, 0, w);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_reset_state("midreset");
        send_beat(8, 0, 1'b1, 0, w);
        idle(4);
        chk("post_reset_phase", self_phase, 62);

        // Randomised frames.
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 24);
            if ($urandom_range(0, 4) == 0) do_init($urandom_range(0, 63));
            for (int b = 0; b < len; b++) begin
                int g, h, st;
                g = int'($urandom_range(0, 255)) - 128;
                h = int'($urandom_range(0, 255)) - 128;
                st = (b == len - 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                if (b > 0 && $urandom_range(0, 5) == 0) freeze($urandom_range(1, 3));
                send_beat(g, h, b == len - 1, st, w);
            end
            idle(3);
        end

        for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
